axis_rr_packet_mux: RTL and testbench

Packet-atomic AXI4-Stream N:1 multiplexer with single-cycle rotating-priority arbitration, per-port enable mask and a registered two-entry output skid buffer. Sits in front of a shared egress stream (DMA or network port) and merges up to S_INTF_NUM upstream packet streams without interleaving beats of different packets. Replaces scan-one-port-per-cycle arbitration: any requesting port can be granted on the next cycle regardless of its position.

---
 rtl/axis_rr_packet_mux.sv | 109 ++++++++++
 tb/tb_axis_rr_packet_mux.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_packet_mux.sv
// axis_rr_packet_mux: packet-atomic AXI4-Stream N:1 mux with rotating priority and a 2-entry output skid.
// Define AXIS_RR_PACKET_MUX_TID_EN to add m_axis_tid and carry the source index through the skid.
module axis_rr_packet_mux #(
   parameter int AXIS_DATA_WIDTH = 512,
   parameter int AXIS_TUSER_WIDTH = 256,
   parameter int S_INTF_NUM = 8,
   localparam int ID_WIDTH = $clog2(S_INTF_NUM)
) (
   input  logic aclk,
   input  logic areset,
   input  logic [S_INTF_NUM-1:0] port_en,
   input  logic [S_INTF_NUM*AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [S_INTF_NUM*AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic [S_INTF_NUM*AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
   input  logic [S_INTF_NUM-1:0] s_axis_tvalid,
   input  logic [S_INTF_NUM-1:0] s_axis_tlast,
   output logic [S_INTF_NUM-1:0] s_axis_tready,
   output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
   output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic [AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
   output logic m_axis_tvalid,
   output logic m_axis_tlast,
`ifdef AXIS_RR_PACKET_MUX_TID_EN
   output logic [ID_WIDTH-1:0] m_axis_tid,
`endif
   input  logic m_axis_tready
);
   localparam int KW = AXIS_DATA_WIDTH/8;
`ifdef AXIS_RR_PACKET_MUX_TID_EN
   localparam int TW = ID_WIDTH;
`else
   localparam int TW = 0;
`endif
   localparam int EW = AXIS_DATA_WIDTH + KW + AXIS_TUSER_WIDTH + 1 + TW;
   typedef enum logic {IDLE, SEND} state_t;
   state_t state_q, state_d;
   logic [ID_WIDTH-1:0] grant_q, grant_d, pick;
   logic [1:0] cnt_q, cnt_d;
   logic [EW-1:0] head_q, head_d, tail_q, tail_d, in_beat;
   logic [S_INTF_NUM-1:0] req;
   logic found, push, pop, wr_hd, head_last;
   int c;
   assign req = s_axis_tvalid & port_en;
   assign push = state_q == SEND && s_axis_tvalid[grant_q] && !cnt_q[1];
   assign pop = m_axis_tvalid && m_axis_tready;
   assign m_axis_tvalid = cnt_q != 2'd0;
   assign m_axis_tlast = m_axis_tvalid && head_last;
`ifdef AXIS_RR_PACKET_MUX_TID_EN
   assign in_beat = {grant_q, s_axis_tlast[grant_q],
                     s_axis_tuser[int'(grant_q)*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH],
                     s_axis_tkeep[int'(grant_q)*KW +: KW],
                     s_axis_tdata[int'(grant_q)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH]};
   assign m_axis_tid = head_q[EW-1 -: ID_WIDTH];
`else
   assign in_beat = {s_axis_tlast[grant_q],
                     s_axis_tuser[int'(grant_q)*AXIS_TUSER_WIDTH +: AXIS_TUSER_WIDTH],
                     s_axis_tkeep[int'(grant_q)*KW +: KW],
                     s_axis_tdata[int'(grant_q)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH]};
`endif
   assign {head_last, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = head_q[EW-TW-1:0];
   // grant_q doubles as last_grant: it keeps the previous winner while IDLE
   always_comb begin
      found = 1'b0;
      pick = grant_q;
      c = 0;
      for (int k = 1; k <= S_INTF_NUM; k++) begin
         c = (int'(grant_q) + k) % S_INTF_NUM;
         if (!found && req[c[ID_WIDTH-1:0]]) begin
            found = 1'b1;
            pick = c[ID_WIDTH-1:0];
         end
      end
   end
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      if (state_q == IDLE && found) begin
         state_d = SEND;
         grant_d = pick;
      end else if (push && s_axis_tlast[grant_q]) begin
         state_d = IDLE;
      end
   end
   always_comb begin
      s_axis_tready = '0;
      s_axis_tready[grant_q] = state_q == SEND && !cnt_q[1];
   end
   // a push lands in the head when the head is empty or leaving this cycle
   always_comb begin
      wr_hd = push && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop));
      head_d = wr_hd ? in_beat : (pop ? tail_q : head_q);
      tail_d = (push && !wr_hd) ? in_beat : tail_q;
      cnt_d = cnt_q + 2'(push) - 2'(pop);
   end
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= IDLE;
         grant_q <= ID_WIDTH'(S_INTF_NUM-1);
         cnt_q <= '0;
         head_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q <= cnt_d;
         head_q <= head_d;
      end
   end
   always_ff @(posedge aclk) tail_q <= tail_d;
endmodule

// File: tb/tb_axis_rr_packet_mux.sv
// tb_axis_rr_packet_mux: scoreboard bench with a packet-level rotating-priority reference model.
module tb_axis_rr_packet_mux;
   localparam int W = 32, U = 8, N = 8, KW = W/8;
   typedef struct packed {
      logic [W-1:0] d;
      logic [KW-1:0] k;
      logic [U-1:0] u;
      logic l;
      logic [2:0] id;
   } beat_t;
   logic aclk = 1'b0, areset = 1'b1;
   logic [N-1:0] port_en = '1;
   logic [N*W-1:0] s_tdata = '0;
   logic [N*KW-1:0] s_tkeep = '0;
   logic [N*U-1:0] s_tuser = '0;
   logic [N-1:0] s_tvalid = '0, s_tlast = '0, s_tready;
   logic [W-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic [U-1:0] m_tuser;
   logic m_tvalid, m_tlast, m_tready = 1'b0;
`ifdef AXIS_RR_PACKET_MUX_TID_EN
   logic [2:0] m_tid;
`endif
   axis_rr_packet_mux #(.AXIS_DATA_WIDTH(W), .AXIS_TUSER_WIDTH(U), .S_INTF_NUM(N)) dut (
      .aclk(aclk), .areset(areset), .port_en(port_en),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
      .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
      .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
`ifdef AXIS_RR_PACKET_MUX_TID_EN
      .m_axis_tid(m_tid),
`endif
      .m_axis_tready(m_tready));
   always #5 aclk = ~aclk;

   beat_t drv_q[N][$];
   beat_t pend[N][$];
   beat_t exp_q[$];
   int checks = 0, errors = 0;
   int model_last = N-1;
   int fired[N];
   int bub[N];
   bit mid[N];
   int mr_mode = 1;
   bit rand_bub = 1'b0, in_rst = 1'b0;
   int occ = 0;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic add_pkt(input int p, input int len, input bit rnd, input logic [W-1:0] base);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.d = rnd ? W'($urandom) : base + W'(i);
         b.k = rnd ? KW'($urandom) : '1;
         b.u = rnd ? U'($urandom) : '0;
         b.l = i == len-1;
         b.id = 3'(p);
         drv_q[p].push_back(b);
         pend[p].push_back(b);
      end
   endtask

   // Packet-level arbitration: next packet comes from the first enabled port with pending work after the last winner.
   task automatic predict(input logic [N-1:0] mask, input int maxp);
      int n = 0;
      bit any;
      beat_t b;
      do begin
         any = 1'b0;
         for (int k = 1; k <= N && !any; k++) begin
            int p = (model_last + k) % N;
            if (mask[p] && pend[p].size() > 0) begin
               any = 1'b1;
               model_last = p;
            end
         end
         if (any) begin
            do begin
               b = pend[model_last].pop_front();
               exp_q.push_back(b);
            end while (!b.l);
            n++;
         end
      end while (any && n < maxp);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge aclk);
      chk(exp_q.size() == 0, name, 64'(exp_q.size()), 0);
      repeat (3) @(negedge aclk);
   endtask

   task automatic wait_fired(input int p, input int target, input string name);
      for (int i = 0; i < 500 && fired[p] < target; i++) @(negedge aclk);
      chk(fired[p] >= target, name, 64'(fired[p]), 64'(target));
   endtask

   task automatic open_ports(input logic [N-1:0] mask);
      repeat (2) @(negedge aclk);
      port_en = mask;
      predict(mask, 999);
   endtask

   // upstream drivers and downstream ready
   initial begin
      logic [N-1:0] sf;
      beat_t b;
      forever begin
         @(negedge aclk);
         sf = s_tvalid & s_tready;
         @(posedge aclk);
         #1;
         for (int p = 0; p < N; p++) begin
            if (sf[p] && drv_q[p].size() > 0) begin
               b = drv_q[p].pop_front();
               fired[p]++;
               mid[p] = !b.l;
               if (rand_bub && mid[p] && $urandom_range(3) == 0) bub[p] = $urandom_range(3, 1);
            end
            if (bub[p] > 0 && mid[p]) begin
               s_tvalid[p] = 1'b0;
               bub[p]--;
            end else begin
               s_tvalid[p] = drv_q[p].size() > 0;
            end
            if (drv_q[p].size() > 0) begin
               s_tdata[p*W +: W] = drv_q[p][0].d;
               s_tkeep[p*KW +: KW] = drv_q[p][0].k;
               s_tuser[p*U +: U] = drv_q[p][0].u;
               s_tlast[p] = drv_q[p][0].l;
            end
         end
         m_tready = mr_mode == 0 ? 1'($urandom_range(1)) : mr_mode == 1 ? 1'b1 : mr_mode == 2 ? 1'b0 : !m_tready;
      end
   end

   // output monitor
   initial begin
      beat_t a, e, hv;
      bit hold = 1'b0;
      hv = '0;
      forever begin
         @(negedge aclk);
         a.d = m_tdata;
         a.k = m_tkeep;
         a.u = m_tuser;
         a.l = m_tlast;
`ifdef AXIS_RR_PACKET_MUX_TID_EN
         a.id = m_tid;
`else
         a.id = '0;
`endif
         if (!in_rst && hold) chk(m_tvalid && a == hv, "stall_stable", 64'(a), 64'(hv));
         if (!in_rst && occ == 2) chk(s_tready == '0, "full_tready", 64'(s_tready), 0);
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_beat", 64'(a), 0);
            end else begin
               e = exp_q.pop_front();
               chk({a.d, a.k, a.u, a.l} == {e.d, e.k, e.u, e.l}, "beat", 64'({a.d, a.k, a.u, a.l}), 64'({e.d, e.k, e.u, e.l}));
`ifdef AXIS_RR_PACKET_MUX_TID_EN
               chk(a.id == e.id, "tid", 64'(a.id), 64'(e.id));
`endif
            end
         end
         if (!in_rst) occ += int'(|(s_tvalid & s_tready)) - int'(m_tvalid && m_tready);
         hold = m_tvalid && !m_tready;
         hv = a;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int n, f;
      logic [N-1:0] mask;
      repeat (3) @(negedge aclk);
      chk(m_tvalid == 1'b0, "rst_m_tvalid", 64'(m_tvalid), 0);
      chk(m_tlast == 1'b0, "rst_m_tlast", 64'(m_tlast), 0);
      chk(s_tready == '0, "rst_s_tready", 64'(s_tready), 0);
`ifdef AXIS_RR_PACKET_MUX_TID_EN
      chk(m_tid == '0, "rst_tid", 64'(m_tid), 0);
`endif
      areset = 1'b0;
      @(negedge aclk);
      // single packet and first-beat latency
      add_pkt(3, 4, 1'b0, 32'h10);
      predict('1, 999);
      for (int i = 0; i < 20 && !s_tvalid[3]; i++) @(negedge aclk);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge aclk);
         n++;
         if (m_tvalid) break;
      end
      chk(n == 2, "first_valid_latency", 64'(n), 2);
      drain("drain_single");
      // fairness across ports 0, 2, 5
      mr_mode = 0;
      port_en = '0;
      for (int r = 0; r < 2; r++) begin
         add_pkt(0, 2, 1'b1, 0);
         add_pkt(2, 2, 1'b1, 0);
         add_pkt(5, 2, 1'b1, 0);
      end
      open_ports('1);
      drain("drain_fair");
      // enable mask, port 1 disabled mid-packet
      port_en = '0;
      add_pkt(0, 3, 1'b1, 0);
      add_pkt(1, 6, 1'b1, 0);
      add_pkt(1, 3, 1'b1, 0);
      repeat (2) @(negedge aclk);
      port_en = 8'hFE;
      predict(8'hFE, 1);
      f = fired[1];
      wait_fired(1, f + 1, "en_first_beat");
      port_en = 8'hFC;
      drain("drain_en");
      repeat (20) @(negedge aclk);
      chk(m_tvalid == 1'b0, "en_no_output", 64'(m_tvalid), 0);
      chk(s_tready == '0, "en_no_grant", 64'(s_tready), 0);
      port_en = '1;
      predict('1, 999);
      drain("drain_en_restore");
      // alternating backpressure over a 16-beat packet
      mr_mode = 3;
      port_en = '0;
      add_pkt(4, 16, 1'b1, 0);
      open_ports('1);
      drain("drain_bp");
      // upstream bubble while port 6 waits
      mr_mode = 1;
      port_en = '0;
      add_pkt(5, 8, 1'b1, 0);
      add_pkt(6, 2, 1'b1, 0);
      open_ports('1);
      f = fired[5];
      wait_fired(5, f + 2, "bubble_start");
      bub[5] = 5;
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         chk(s_tready[6] == 1'b0, "bubble_no_grant6", 64'(s_tready), 0);
      end
      drain("drain_bubble");
      // reset mid-packet with a full skid
      mr_mode = 2;
      add_pkt(2, 4, 1'b1, 0);
      predict('1, 999);
      f = fired[2];
      wait_fired(2, f + 2, "rst_two_beats");
      repeat (3) @(negedge aclk);
      in_rst = 1'b1;
      areset = 1'b1;
      while (drv_q[2].size() > 0) void'(drv_q[2].pop_front());
      mid[2] = 1'b0;
      bub[2] = 0;
      exp_q.delete();
      @(negedge aclk);
      areset = 1'b0;
      chk(m_tvalid == 1'b0, "midrst_m_tvalid", 64'(m_tvalid), 0);
      chk(m_tlast == 1'b0, "midrst_m_tlast", 64'(m_tlast), 0);
      chk(s_tready == '0, "midrst_s_tready", 64'(s_tready), 0);
      occ = 0;
      in_rst = 1'b0;
      model_last = N-1;
      mr_mode = 1;
      port_en = '0;
      add_pkt(4, 2, 1'b1, 0);
      add_pkt(0, 2, 1'b1, 0);
      open_ports('1);
      drain("drain_after_rst");
      // randomized rounds with random masks, bubbles and ready
      mr_mode = 0;
      rand_bub = 1'b1;
      for (int r = 0; r < 12; r++) begin
         port_en = '0;
         for (int p = 0; p < N; p++)
            if ($urandom_range(1) == 1)
               for (int k = $urandom_range(3, 1); k > 0; k--) add_pkt(p, $urandom_range(6, 1), 1'b1, 0);
         mask = N'($urandom) | N'(1 << $urandom_range(N-1));
         open_ports(mask);
         drain("drain_rand");
      end
      port_en = '0;
      open_ports('1);
      drain("drain_final");
      rand_bub = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
